// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind an IDLE/WAIT/RESP handshake
// with programmable access latency, byte-lane store merging and load extension.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata
);
    localparam int         IW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          we_q;
    logic [IW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [IW-1:0] idx;
    logic [1:0]    off;
    logic          f3_bad, misalign, acc_err, access, mem_we;
    logic [3:0]    be;
    logic [31:0]   wrep, word, merged, ld_val;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    // Address bits above the index only alias; they are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:IW+2];

    assign idx  = addr_q[IW+1:2];
    assign off  = addr_q[1:0];
    assign word = mem[idx];

    always_comb begin
        f3_bad   = 1'b0;
        misalign = 1'b0;
        be       = 4'b0000;
        wrep     = wdata_q;
        case (f3_q)
            3'b000, 3'b100: begin
                be   = 4'b0001 << off;
                wrep = {4{wdata_q[7:0]}};
            end
            3'b001, 3'b101: begin
                misalign = off[0];
                be       = off[1] ? 4'b1100 : 4'b0011;
                wrep     = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                misalign = |off;
                be       = 4'b1111;
            end
            default: f3_bad = 1'b1;
        endcase
        // Unsigned sizes exist only for loads.
        if (we_q && f3_q[2])
            f3_bad = 1'b1;
    end

    assign acc_err = f3_bad | misalign;
    assign access  = (state == WAIT) && (cnt == 4'd0);
    assign mem_we  = access && we_q && !acc_err && !rst;

    always_comb begin
        for (int i = 0; i < 4; i++)
            merged[i*8 +: 8] = be[i] ? wrep[i*8 +: 8] : word[i*8 +: 8];
    end

    assign ld_byte = word[{off, 3'b000} +: 8];
    assign ld_half = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_val = '0;
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'd0, ld_half};
            3'b010:  ld_val = word;
            default: ld_val = '0;
        endcase
    end

    // RAM contents survive reset; only the write strobe is reset-qualified.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx] <= merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            busy    <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 1'b0;
                    err <= 1'b0;
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr[IW+1:0];
                        wdata_q <= wdata;
                        f3_q    <= funct3;
                        cnt     <= CNT_INIT;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ack <= 1'b1;
                        err <= acc_err;
                        if (!we_q)
                            rdata <= acc_err ? 32'd0 : ld_val;
                        state <= RESP;
                    end
                end
                RESP: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the core side of the load/store path. It answers word, halfword and byte requests issued by the multicycle control path during its MEMORY state.
- Holds a word-organised RAM and applies a configurable access latency.
- Performs byte-lane merging on stores and sign/zero extension on loads, then returns a one-cycle acknowledge with read data or an error flag.
- Sits between the control/datapath and the data-memory array; replaces the direct single-cycle DMemWrite path.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two; the index is addr[log2(DEPTH_WORDS)+1:2].
- LATENCY, 2, WAIT cycles between request capture and access; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load; captured with req.
- addr  input  32  byte address; captured with req.
- wdata  input  32  store data; low byte/half used for SB/SH; captured with req.
- funct3  input  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- busy  output  1  high in WAIT and RESP.
- ack  output  1  one-cycle completion pulse.
- err  output  1  valid with ack; misaligned access or illegal funct3.
- rdata  output  32  extended load result; valid with ack.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; busy=0, ack=0, err=0, rdata=0, latency counter=0.
  - RAM contents are not reset.
  - Reset asserted mid-transaction aborts it: no write is committed, no ack is issued.
- States: IDLE, WAIT, RESP; 2-bit state register; all outputs registered.
- IDLE:
  - On an edge with req=1, capture we/addr/wdata/funct3, set counter to LATENCY-1, go to WAIT, busy=1.
  - req=0 stays in IDLE.
- WAIT:
  - While counter != 0, decrement it.
  - On the edge with counter == 0, perform the access, register rdata/err, set ack=1 and go to RESP.
  - req is ignored throughout WAIT.
- RESP:
  - ack is high for exactly this cycle.
  - On the next edge: ack=0, err=0, busy=0, go to IDLE.
  - rdata holds its value until the next completed load.
  - req is ignored in RESP.
- Latency: req sampled at edge E0 gives ack high between edges E(LATENCY) and E(LATENCY+1). The earliest next request is accepted at edge E(LATENCY+2).
- Alignment:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=00.
  - B/BU is always aligned.
- Error cases:
  - Misaligned access or funct3 in {011, 110, 111} gives err=1 with ack.
  - No write is committed.
  - rdata is forced to 0 for loads; unchanged for stores.
- Stores:
  - Read-modify-write of the addressed word in the access cycle.
  - SB writes wdata[7:0] into lane addr[1:0].
  - SH writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - SW writes the full word.
  - Unaddressed lanes are preserved.
  - funct3 100/101 with we=1 is illegal and raises err.
- Loads:
  - Select the lane by addr[1:0].
  - B sign-extends bit 7; BU zero-extends.
  - H sign-extends bit 15; HU zero-extends.
  - W passes the word through.
  - Stores leave rdata unchanged.
- Address wrap: upper address bits above the index are ignored, so accesses alias modulo DEPTH_WORDS*4 bytes with no error.
- Simultaneous events: req held high continuously gives back-to-back transactions, each separated by the RESP cycle plus one IDLE cycle. A change in inputs after capture does not affect the transaction in flight.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 (LATENCY=2): ack two edges after req capture on each access; rdata=0xDEADBEEF; err=0; busy high 3 cycles per access.
- After the SW above, SB addr=0x11 wdata=0x000000A5, then LW 0x10 gives 0xDEADA5EF; LB 0x11 gives 0xFFFFFFA5; LBU 0x11 gives 0x000000A5.
- SH 0x12 wdata=0x00008001, then LH 0x12 gives 0xFFFF8001; LHU 0x12 gives 0x00008001; LH 0x13 gives err=1, rdata=0; SW 0x12 gives err=1 and LW 0x10 afterwards still gives 0x8001A5EF.
- Reset asserted during WAIT of SW 0x20 wdata=0x12345678: busy/ack drop immediately with no ack pulse; a following LW 0x20 returns the prior contents (0x00000000 if preloaded with zero).
- req held high with wdata changed one cycle after capture: each transaction uses its captured values; funct3=011 gives err=1; addr 0x1000+0x10 with DEPTH_WORDS=1024 aliases 0x10.
- LATENCY=1 and LATENCY=15 builds: ack appears exactly LATENCY edges after the capture edge; exactly one ack pulse per captured req.
